// File: rtl/fadd_result_wb_if.sv
// Valid/ready bus between the FP adder, the writeback FIFO and the commit consumer.
// The slave modport is the writeback stage. The master modport is the adder plus the consumer.
interface fadd_result_wb_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [4:0]  in_flags;
    logic        in_mode_fp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_flags;
    logic        out_mode_fp;

    modport slave (
        input  in_valid, in_result, in_flags, in_mode_fp, out_ready,
        output in_ready, out_valid, out_result, out_flags, out_mode_fp
    );

    modport master (
        output in_valid, in_result, in_flags, in_mode_fp, out_ready,
        input  in_ready, out_valid, out_result, out_flags, out_mode_fp
    );
endinterface

// File: rtl/fadd_result_wb.sv
// FP adder writeback: a small result/flags FIFO with a sticky accumulated-flags register.
// The accumulator is built only when FADD_WB_FLAG_ACC_EN is defined; otherwise acc_flags reads 0.
module fadd_result_wb #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    fadd_result_wb_if.slave     bus,
    output logic [AW:0]         count,
    input  logic                flag_clr,
    output logic [4:0]          acc_flags
);

    typedef struct packed {
        logic        mode_fp;
        logic [4:0]  flags;
        logic [31:0] result;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          in_entry;
    entry_t          head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    // Full and empty come from the occupancy count, so wr_ptr == rd_ptr is never ambiguous.
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign push  = bus.in_valid & ~full;
    assign pop   = ~empty & bus.out_ready;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        in_entry         = '0;
        in_entry.mode_fp = bus.in_mode_fp;
        in_entry.flags   = bus.in_flags;
        in_entry.result  = bus.in_mode_fp ? bus.in_result : {16'h0, bus.in_result[15:0]};
    end

    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
        end
    end

    // NOTE: storage has no reset; the pointers and count decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_entry;
    end

    assign head            = mem[rd_ptr];
    assign bus.in_ready    = ~full;
    assign bus.out_valid   = ~empty;
    assign bus.out_result  = empty ? 32'h0 : head.result;
    assign bus.out_flags   = empty ? 5'h0  : head.flags;
    assign bus.out_mode_fp = empty ? 1'b0  : head.mode_fp;

`ifdef FADD_WB_FLAG_ACC_EN
    // Flags are committed at pop. A clear in the same cycle is applied before the OR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_flags <= '0;
        end else if (pop) begin
            acc_flags <= (flag_clr ? 5'h0 : acc_flags) | bus.out_flags;
        end else if (flag_clr) begin
            acc_flags <= '0;
        end
    end
`else
    logic unused_flag_clr;
    assign unused_flag_clr = flag_clr;
    assign acc_flags       = '0;
`endif

endmodule
